// File: rtl/mult_control_taint_param_pkg.sv
// Shared types for the taint-tracking shift-add multiplier controller.
// State encoding and index-width helper.
package mult_control_taint_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_TEST  = 3'd2,
    ST_ADD   = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5,
    ST_STEP  = 3'd6
  } state_e;

  function automatic int idx_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mult_control_taint_param_taint_bit_select.sv
// Indexed bit select that carries the selected bit's taint alongside it.
// Shared with the datapath taint shadow.
module taint_bit_select
  import mult_control_taint_param_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] val,
  input  logic [WIDTH-1:0] val_t,
  input  logic [IDX_W-1:0] idx,
  output logic             bit_o,
  output logic             bit_t
);

  assign bit_o = val[idx];
  assign bit_t = val_t[idx];

endmodule

// File: rtl/mult_control_taint_param.sv
// Control FSM for the sequential shift-add multiplier, walking the
// multiplier with a bit index and carrying a single taint shadow.
module mult_control_taint_param
  import mult_control_taint_param_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit FAST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic [WIDTH-1:0] multiplierReg_t,
  output logic             busy,
  output logic             busy_t,
  output logic             productDone,
  output logic             productDone_t,
  output logic             rsload,
  output logic             rsload_t,
  output logic             rsclear,
  output logic             rsclear_t,
  output logic             rsshr,
  output logic             rsshr_t,
  output logic             mrld,
  output logic             mrld_t,
  output logic             mdld,
  output logic             mdld_t
);

  localparam int            IW   = idx_w(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          state_t_q, state_t_d;
  logic          sel, sel_t;

  taint_bit_select #(
    .WIDTH(WIDTH),
    .IDX_W(IW)
  ) u_sel (
    .val  (multiplierReg),
    .val_t(multiplierReg_t),
    .idx  (idx_q),
    .bit_o(sel),
    .bit_t(sel_t)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      state_t_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      state_t_q <= state_t_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    state_t_d = state_t_q;
    unique case (state_q)
      ST_IDLE: begin
        // idle taint follows start_t so a tainted decision to start is seen
        state_t_d = start_t;
        if (start) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      end
      ST_INIT: state_d = FAST ? ST_STEP : ST_TEST;
      ST_TEST: begin
        state_t_d = state_t_q | sel_t;
        state_d   = sel ? ST_ADD : ST_SHIFT;
      end
      ST_ADD: state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (idx_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + ONE;
          state_d = ST_TEST;
        end
      end
      ST_STEP: begin
        state_t_d = state_t_q | sel_t;
        if (idx_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + ONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != ST_IDLE);
    productDone   = 1'b0;
    rsload        = 1'b0;
    rsclear       = 1'b0;
    rsshr         = 1'b0;
    mrld          = 1'b0;
    mdld          = 1'b0;
    busy_t        = state_t_q;
    productDone_t = state_t_q;
    rsload_t      = state_t_q;
    rsclear_t     = state_t_q;
    rsshr_t       = state_t_q;
    mrld_t        = state_t_q;
    mdld_t        = state_t_q;
    unique case (state_q)
      ST_INIT: begin
        mdld    = 1'b1;
        mrld    = 1'b1;
        rsclear = 1'b1;
      end
      ST_ADD:   rsload = 1'b1;
      ST_SHIFT: rsshr  = 1'b1;
      ST_STEP: begin
        // the add decision comes straight from the selected bit
        rsshr    = 1'b1;
        rsload   = sel;
        rsload_t = state_t_q | sel_t;
      end
      ST_DONE: productDone = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_control_taint_param.sv
// Scoreboard bench: lane 0 is WIDTH=4 FAST=0, lane 1 is WIDTH=8 FAST=1.
// Expected per-cycle output vectors are queued at issue and popped by a monitor.
module tb_mult_control_taint_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start   [2];
  logic       start_t [2];
  logic [7:0] mr      [2];
  logic [7:0] mrt     [2];
  wire  [13:0] ov0, ov1;

  int n_vec = 0;
  int n_bad = 0;
  logic [13:0] q0[$];
  logic [13:0] q1[$];
  logic idle_t [2];
  bit   chk_en = 1'b0;

  mult_control_taint_param #(.WIDTH(4), .FAST(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .start_t(start_t[0]),
    .multiplierReg(mr[0][3:0]), .multiplierReg_t(mrt[0][3:0]),
    .busy(ov0[13]), .productDone(ov0[12]), .rsload(ov0[11]),
    .rsclear(ov0[10]), .rsshr(ov0[9]), .mrld(ov0[8]), .mdld(ov0[7]),
    .busy_t(ov0[6]), .productDone_t(ov0[5]), .rsload_t(ov0[4]),
    .rsclear_t(ov0[3]), .rsshr_t(ov0[2]), .mrld_t(ov0[1]), .mdld_t(ov0[0])
  );

  mult_control_taint_param #(.WIDTH(8), .FAST(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .start_t(start_t[1]),
    .multiplierReg(mr[1]), .multiplierReg_t(mrt[1]),
    .busy(ov1[13]), .productDone(ov1[12]), .rsload(ov1[11]),
    .rsclear(ov1[10]), .rsshr(ov1[9]), .mrld(ov1[8]), .mdld(ov1[7]),
    .busy_t(ov1[6]), .productDone_t(ov1[5]), .rsload_t(ov1[4]),
    .rsclear_t(ov1[3]), .rsshr_t(ov1[2]), .mrld_t(ov1[1]), .mdld_t(ov1[0])
  );

  // strobes order: busy, done, rsload, rsclear, rsshr, mrld, mdld
  function automatic logic [13:0] mk(logic [6:0] s, logic t, logic tl);
    return {s, t, t, tl, t, t, t, t};
  endfunction

  function automatic void push(int ln, logic [13:0] v);
    if (ln == 0) q0.push_back(v);
    else q1.push_back(v);
  endfunction

  function automatic void chk(string nm, int ln, logic [13:0] g, logic [13:0] e);
    n_vec++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s lane%0d t=%0t got=%b exp=%b", nm, ln, $time, g, e);
    end
  endfunction

  // Build the cycle-by-cycle schedule of one multiplication.
  function automatic int gen(int ln, logic [7:0] m, logic [7:0] mt, logic st);
    int   w = (ln == 0) ? 4 : 8;
    logic t = st;
    int   n = 0;
    push(ln, mk(7'b1001011, t, t)); n++;
    for (int i = 0; i < w; i++) begin
      if (ln == 0) begin
        push(ln, mk(7'b1000000, t, t)); n++;
        t = t | mt[i];
        if (m[i]) begin
          push(ln, mk(7'b1010000, t, t)); n++;
        end
        push(ln, mk(7'b1000100, t, t)); n++;
      end else begin
        push(ln, mk(7'b1000100 | {2'b00, m[i], 4'b0000}, t, t | mt[i])); n++;
        t = t | mt[i];
      end
    end
    push(ln, mk(7'b1100000, t, t)); n++;
    return n;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int ln = 0; ln < 2; ln++) begin
        logic [13:0] got;
        logic [13:0] e;
        int          sz;
        got = (ln == 0) ? ov0 : ov1;
        sz  = (ln == 0) ? q0.size() : q1.size();
        if (sz > 0) begin
          if (ln == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk("trace", ln, got, e);
          if (e[12]) idle_t[ln] = e[0];
        end else begin
          chk("idle", ln, got, {7'b0, {7{idle_t[ln]}}});
          idle_t[ln] = start_t[ln];
        end
        if (!rst) begin
          if (ln == 0) q0.delete();
          else q1.delete();
          idle_t[ln] = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) begin
      start[0]   = 1'b0;
      start[1]   = 1'b0;
      start_t[0] = 1'($urandom);
      start_t[1] = 1'($urandom);
      step();
    end
  endtask

  // Issue start this cycle; garbage start/start_t while busy must be ignored.
  task automatic run_op(int ln, logic [7:0] m, logic [7:0] mt, logic st, int rst_at);
    int len;
    mr[ln]      = m;
    mrt[ln]     = mt;
    start[ln]   = 1'b1;
    start_t[ln] = st;
    step();
    len = gen(ln, m, mt, st);
    for (int j = 1; j <= len; j++) begin
      start[ln]   = 1'($urandom);
      start_t[ln] = 1'($urandom);
      if (j == rst_at) begin
        rst       = 1'b0;
        start[ln] = 1'b0;
        step();
        rst         = 1'b1;
        start_t[ln] = 1'b0;
        return;
      end
      step();
    end
    start[ln]   = 1'b0;
    start_t[ln] = 1'b0;
  endtask

  initial begin
    logic [7:0] m;
    logic [7:0] mt;
    logic       st;
    int         ln;
    int         ra;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i]   = 1'b0;
      start_t[i] = 1'b0;
      mr[i]      = 8'h00;
      mrt[i]     = 8'h00;
    end
    step();
    step();
    idle_t[0] = 1'b0;
    idle_t[1] = 1'b0;
    chk_en    = 1'b1;
    step();
    step();
    rst = 1'b1;

    run_op(0, 8'h0B, 8'h00, 1'b0, 0);
    run_op(0, 8'h0B, 8'h04, 1'b0, 0);
    idle(1);
    start[0]   = 1'b0;
    start_t[0] = 1'b0;
    step();
    step();
    start_t[0] = 1'b1;
    step();
    run_op(0, 8'h06, 8'h00, 1'b0, 0);
    idle(2);
    run_op(0, 8'h0B, 8'h00, 1'b0, 8);
    idle(2);
    run_op(0, 8'h0B, 8'h00, 1'b0, 0);
    idle(2);
    run_op(1, 8'hA5, 8'h01, 1'b0, 0);
    idle(2);

    repeat (40) begin
      ln = $urandom_range(0, 1);
      m  = 8'($urandom);
      mt = ($urandom_range(0, 1) == 1) ? 8'($urandom & $urandom & $urandom) : 8'h00;
      st = ($urandom_range(0, 3) == 0);
      ra = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 10)) : 0;
      run_op(ln, m, mt, st, ra);
      idle($urandom_range(0, 2));
    end

    idle(3);
    n_vec++;
    if (q0.size() + q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d exp=0", q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
